// File: rtl/ct_loader_if.sv
// ct_loader_if: bus bundle between the ciphertext loader and its environment.
//   in_valid/in_ready/in_data          byte stream into the loader
//   em_addr/em_wrdata/em_wren          write port A of the encrypted-message memory
//   crack_valid/crack_ready            start handshake to the cracker
//   crack_key/crack_found              cracker result, valid while crack_ready=1
// Modports:
//   slave  - the loader (ct_loader) view
//   master - the environment view (byte source, memory, cracker)
// Handshake semantics: a transfer happens on a rising clk edge where valid and
// ready are both high. The stream source holds in_data stable while in_valid is
// high and not accepted. crack_valid is a single-cycle pulse, raised only after
// the loader has seen crack_ready=1; the cracker takes it as accepted by
// dropping crack_ready.
interface ct_loader_if #(
  parameter int LEN_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic [LEN_W-1:0] em_addr;
  logic [7:0]       em_wrdata;
  logic             em_wren;
  logic             crack_valid;
  logic             crack_ready;
  logic [23:0]      crack_key;
  logic             crack_found;

  modport slave (
    input  in_valid, in_data, crack_ready, crack_key, crack_found,
    output in_ready, em_addr, em_wrdata, em_wren, crack_valid
  );

  modport master (
    output in_valid, in_data, crack_ready, crack_key, crack_found,
    input  in_ready, em_addr, em_wrdata, em_wren, crack_valid
  );
endinterface

// File: rtl/ct_loader.sv
// ct_loader: front end of the brute-force cracker.
// Accepts a length-prefixed ciphertext byte stream (byte 0 = L, bytes 1..L =
// ciphertext), writes every byte into the encrypted-message memory at its stream
// index, starts the cracker with one crack_valid pulse, waits for completion and
// holds key, found flag and cycle count for the display.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   bus             ct_loader_if.slave (byte stream, memory write port, cracker)
//   abort           synchronous abort; honoured in IDLE/LOAD/START only
//   busy            high in every state except IDLE
//   done            one-cycle pulse in the cycle the result registers change
//   err             last message had L==0
//   result_key      held key of the last completed crack
//   result_found    held found flag
//   result_cycles   cycles from crack_valid to completion, saturating
//   dbg_state       current FSM state
// All outputs are registered. A memory write is issued the cycle after its byte
// is accepted and is never cancelled by a state change or abort.
module ct_loader #(
  parameter int LEN_W = 8,
  parameter int CYC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  ct_loader_if.slave       bus,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [23:0]      result_key,
  output logic             result_found,
  output logic [CYC_W-1:0] result_cycles,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_START     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_REPORT    = 3'd5
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic             settle;
  logic [CYC_W-1:0] cyc;
  logic             accept;

  assign accept    = bus.in_valid && bus.in_ready;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      len_q            <= '0;
      cnt              <= '0;
      settle           <= 1'b0;
      cyc              <= '0;
      bus.in_ready     <= 1'b0;
      bus.em_addr      <= '0;
      bus.em_wrdata    <= '0;
      bus.em_wren      <= 1'b0;
      bus.crack_valid  <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      result_key       <= '0;
      result_found     <= 1'b0;
      result_cycles    <= '0;
    end else begin
      // Single-cycle strobes; re-asserted below only when needed.
      bus.em_wren     <= 1'b0;
      bus.crack_valid <= 1'b0;
      done            <= 1'b0;

      case (state)
        S_IDLE: begin
          bus.in_ready <= 1'b1;
          // A byte arriving together with abort is consumed and dropped.
          if (accept && !abort) begin
            bus.em_wren   <= 1'b1;
            bus.em_addr   <= '0;
            bus.em_wrdata <= bus.in_data;
            len_q         <= LEN_W'(bus.in_data);
            cnt           <= LEN_W'(1);
            busy          <= 1'b1;
            if (bus.in_data == 8'd0) begin
              // Empty message: report an error without touching the cracker.
              err           <= 1'b1;
              result_found  <= 1'b0;
              result_key    <= '0;
              result_cycles <= '0;
              done          <= 1'b1;
              bus.in_ready  <= 1'b0;
              state         <= S_REPORT;
            end else begin
              err   <= 1'b0;
              state <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          if (abort) begin
            bus.in_ready <= 1'b1;
            busy         <= 1'b0;
            state        <= S_IDLE;
          end else if (accept) begin
            bus.em_wren   <= 1'b1;
            bus.em_addr   <= cnt;
            bus.em_wrdata <= bus.in_data;
            cnt           <= cnt + 1'b1;
            if (cnt == len_q) begin
              bus.in_ready <= 1'b0;
              settle       <= 1'b1;
              state        <= S_START;
            end
          end
        end

        S_START: begin
          if (abort) begin
            settle       <= 1'b0;
            bus.in_ready <= 1'b1;
            busy         <= 1'b0;
            state        <= S_IDLE;
          end else if (settle) begin
            // Let the final memory write land before the cracker starts reading.
            settle <= 1'b0;
          end else if (bus.crack_ready) begin
            bus.crack_valid <= 1'b1;
            cyc             <= '0;
            state           <= S_WAIT_BUSY;
          end
        end

        S_WAIT_BUSY: begin
          cyc <= (&cyc) ? cyc : cyc + 1'b1;
          if (!bus.crack_ready) begin
            state <= S_WAIT_DONE;
          end
        end

        S_WAIT_DONE: begin
          cyc <= (&cyc) ? cyc : cyc + 1'b1;
          if (bus.crack_ready) begin
            result_key    <= bus.crack_key;
            result_found  <= bus.crack_found;
            result_cycles <= cyc;
            done          <= 1'b1;
            state         <= S_REPORT;
          end
        end

        S_REPORT: begin
          bus.in_ready <= 1'b1;
          busy         <= 1'b0;
          state        <= S_IDLE;
        end

        default: begin
          bus.in_ready <= 1'b1;
          busy         <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ct_loader.sv
// tb_ct_loader: randomized scoreboard bench for ct_loader.
// Memory writes are modelled as (stream index, byte) pairs expected one cycle
// after the byte is accepted; results come from a behavioural cracker model that
// knows its own latency, key and found flag.
module tb_ct_loader;
  localparam int LEN_W = 8;
  localparam int CYC_W = 32;

  logic             clk;
  logic             rst;
  logic             abort;
  logic             busy;
  logic             done;
  logic             err;
  logic [23:0]      result_key;
  logic             result_found;
  logic [CYC_W-1:0] result_cycles;
  logic [2:0]       dbg_state;

  ct_loader_if #(.LEN_W(LEN_W)) bus ();

  ct_loader #(.LEN_W(LEN_W), .CYC_W(CYC_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .abort         (abort),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .result_key    (result_key),
    .result_found  (result_found),
    .result_cycles (result_cycles),
    .dbg_state     (dbg_state)
  );

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  // {cycle[31:0], addr[7:0], data[7:0]}
  logic [47:0] exp_wr_q[$];
  // {err, found, key[23:0], cycles[31:0]}
  logic [57:0] exp_res_q[$];
  logic [57:0] model_res = '0;

  int exp_starts  = 0;
  int exp_done    = 0;
  int starts_seen = 0;
  int done_seen   = 0;

  bit          ck_cfg = 1'b0;
  int          ck_cfg_d;
  logic [23:0] ck_cfg_key;
  logic        ck_cfg_found;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_n <= cyc_n + 1;

  initial begin
    #900000;
    total++;
    bad++;
    $display("FAIL watchdog: time limit reached, required finish before it");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int act);
    total++;
    bad++;
    $display("FAIL %s: got %0d, required none", name, act);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_em_wren"}, bus.em_wren, 0);
    check({tag, "_em_addr"}, bus.em_addr, 0);
    check({tag, "_em_wrdata"}, bus.em_wrdata, 0);
    check({tag, "_crack_valid"}, bus.crack_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_result_key"}, result_key, 0);
    check({tag, "_result_found"}, result_found, 0);
    check({tag, "_result_cycles"}, result_cycles, 0);
  endtask

  // ---------------- driver tasks ----------------
  // mode: 0 back-to-back, 1 one idle cycle before every byte, 2 random gaps
  task automatic send_byte(input logic [7:0] b, input logic [7:0] idx, input int mode);
    int n;
    bit rdy;
    @(negedge clk);
    if (mode == 1 || (mode == 2 && $urandom_range(3, 0) == 0)) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n   = 0;
    rdy = bus.in_ready;
    while (!rdy && n < 200) begin
      @(negedge clk);
      rdy = bus.in_ready;
      n++;
    end
    if (!rdy) begin
      fail_now("in_ready_timeout", n);
      bus.in_valid = 1'b0;
    end else begin
      exp_wr_q.push_back({32'(cyc_n + 1), idx, b});
      @(posedge clk);
    end
  endtask

  task automatic do_abort();
    @(negedge clk);
    bus.in_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_hold_err", err, model_res[57]);
    check("abort_hold_found", result_found, model_res[56]);
    check("abort_hold_key", result_key, model_res[55:32]);
    check("abort_hold_cycles", result_cycles, model_res[31:0]);
  endtask

  // abort_after < 0: complete message; otherwise abort after that many payload bytes.
  task automatic send_msg(input int len, input int mode, input int abort_after, input bit fixed);
    logic [7:0] b;
    if (len == 0) begin
      model_res = {1'b1, 1'b0, 24'd0, 32'd0};
      exp_res_q.push_back(model_res);
      exp_done++;
    end
    send_byte(8'(len), 8'd0, mode);
    if (len > 0) model_res[57] = 1'b0;
    for (int i = 1; i <= len; i++) begin
      if (abort_after >= 0 && i > abort_after) break;
      b = fixed ? 8'(8'hA1 + (i - 1) * 8'h11) : 8'($urandom_range(255, 0));
      send_byte(b, 8'(i), mode);
    end
    if (abort_after >= 0) begin
      do_abort();
    end else begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (len > 0) begin
        exp_starts++;
        exp_done++;
      end
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_seen < exp_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (done_seen < exp_done) fail_now("done_timeout", done_seen);
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 1);
    check("idle_busy", busy, 0);
  endtask

  // ---------------- cracker model ----------------
  initial begin
    int          rem;
    bit          pend;
    int          d;
    logic [23:0] k;
    logic        f;
    rem  = 0;
    pend = 1'b0;
    bus.crack_ready = 1'b1;
    bus.crack_key   = '0;
    bus.crack_found = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rem  = 0;
        pend = 1'b0;
        bus.crack_ready = 1'b1;
      end else if (pend) begin
        if (rem > 0) begin
          // Garbage on key/found while busy: only the completion cycle counts.
          bus.crack_ready = 1'b0;
          bus.crack_key   = 24'($urandom);
          bus.crack_found = 1'($urandom_range(1, 0));
          rem--;
        end else begin
          bus.crack_ready = 1'b1;
          bus.crack_key   = k;
          bus.crack_found = f;
          pend = 1'b0;
        end
      end else if (bus.crack_valid && bus.crack_ready) begin
        if (ck_cfg) begin
          d = ck_cfg_d;
          k = ck_cfg_key;
          f = ck_cfg_found;
          ck_cfg = 1'b0;
        end else begin
          d = $urandom_range(20, 1);
          k = 24'($urandom);
          f = 1'($urandom_range(1, 0));
        end
        rem  = d;
        pend = 1'b1;
        // Accept cycle plus d busy cycles elapse before completion is seen.
        model_res = {1'b0, f, k, 32'(d + 1)};
        exp_res_q.push_back(model_res);
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic        prev_cv;
    logic        prev_done;
    logic [47:0] w;
    logic [57:0] r;
    prev_cv   = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_cv   = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (bus.em_wren) begin
          if (exp_wr_q.size() == 0) begin
            fail_now("wr_unexpected_addr", int'(bus.em_addr));
          end else begin
            w = exp_wr_q.pop_front();
            check("wr_cycle", 64'(cyc_n), 64'(w[47:16]));
            check("wr_addr", bus.em_addr, w[15:8]);
            check("wr_data", bus.em_wrdata, w[7:0]);
          end
        end
        if (bus.crack_valid) begin
          starts_seen++;
          check("cv_single_cycle", prev_cv, 0);
          check("cv_writes_pending", exp_wr_q.size(), 0);
          check("cv_with_wren", bus.em_wren, 0);
          check("cv_in_ready", bus.in_ready, 0);
        end
        if (done) begin
          done_seen++;
          check("done_single_cycle", prev_done, 0);
          check("done_busy", busy, 1);
          if (exp_res_q.size() == 0) begin
            fail_now("done_unexpected", done_seen);
          end else begin
            r = exp_res_q.pop_front();
            check("res_err", err, r[57]);
            check("res_found", result_found, r[56]);
            check("res_key", result_key, r[55:32]);
            check("res_cycles", result_cycles, r[31:0]);
          end
        end
        prev_cv   = bus.crack_valid;
        prev_done = done;
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int n;
    rst          = 1'b0;
    abort        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b0;
    check("por_in_ready_low", bus.in_ready, 0);
    @(negedge clk);
    check("por_in_ready_first_clk", bus.in_ready, 1);

    // L=3 back-to-back, cracker busy 10 cycles with key 0x00001F found
    ck_cfg_d = 10; ck_cfg_key = 24'h00001F; ck_cfg_found = 1'b1; ck_cfg = 1'b1;
    send_msg(3, 0, -1, 1'b1);
    wait_done();
    check("t2_result_key", result_key, 24'h00001F);
    check("t2_result_found", result_found, 1);
    check("t2_result_cycles", result_cycles, 11);

    // empty message
    send_msg(0, 0, -1, 1'b0);
    wait_done();
    check("t3_err", err, 1);
    check("t3_found", result_found, 0);

    // maximum length with in_valid toggling
    send_msg(255, 1, -1, 1'b0);
    wait_done();

    // abort mid-LOAD, then a one-byte message
    send_msg(5, 2, 2, 1'b0);
    send_msg(1, 0, -1, 1'b0);
    wait_done();

    // abort while in START (all payload loaded)
    send_msg(4, 2, 4, 1'b0);
    repeat (3) @(negedge clk);

    // randomized messages
    for (int m = 0; m < 10; m++) begin
      n = ($urandom_range(5, 0) == 0) ? 0 : $urandom_range(24, 1);
      send_msg(n, ($urandom_range(1, 0) == 1) ? 2 : 0, -1, 1'b0);
      wait_done();
    end

    // reset while waiting on the cracker
    ck_cfg_d = 40; ck_cfg_key = 24'hABCDEF; ck_cfg_found = 1'b1; ck_cfg = 1'b1;
    send_msg(2, 0, -1, 1'b0);
    n = 0;
    while (starts_seen < exp_starts && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (starts_seen < exp_starts) fail_now("start_timeout", starts_seen);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals("mid");
    exp_wr_q.delete();
    exp_res_q.delete();
    model_res = '0;
    exp_done--;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("mid_in_ready_low", bus.in_ready, 0);
    @(negedge clk);
    check("mid_in_ready_first_clk", bus.in_ready, 1);
    check("mid_crack_valid", bus.crack_valid, 0);

    // recovery
    send_msg(6, 2, -1, 1'b0);
    wait_done();

    repeat (5) @(negedge clk);
    check("final_starts", starts_seen, exp_starts);
    check("final_dones", done_seen, exp_done);
    check("final_wr_q_empty", exp_wr_q.size(), 0);
    check("final_res_q_empty", exp_res_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
